vga_timing_receiver: RTL and testbench

- Sink end of the VGA output interface: samples vga_h_sync, vga_v_sync and the 4-bit RGB lines on the pixel clock.
- Measures line and frame timing and locks to the 640x480@60 format.
- Recovers per-pixel coordinates and colour.
- Used as an on-chip loopback checker for picture_generator and for frame capture in the stack-calculator display path.

---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/vga_sync_edge_detect.sv | 31 +++
 rtl/vga_timing_receiver.sv | 178 +++++++++++++++++
 tb/tb_vga_timing_receiver.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, receiver FSM states and the RGB444 pixel type
// for the VGA sink-side timing receiver.
package vga_timing_pkg;

  localparam int   H_TOTAL     = 800;
  localparam int   H_BACK      = 144;
  localparam int   H_ACTIVE    = 640;
  localparam int   V_TOTAL     = 525;
  localparam int   V_BACK      = 35;
  localparam int   V_ACTIVE    = 480;
  localparam logic SYNC_ACTIVE = 1'b0;
  localparam int   LOCK_FRAMES = 2;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } rx_state_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

endpackage

// File: rtl/vga_sync_edge_detect.sv
// Two-flop sampler for one sync pin; pulses lead_edge while the newest sample is
// the first one at the active level.
module vga_sync_edge_detect
  import vga_timing_pkg::*;
#(
  parameter logic ACTIVE_LEVEL = SYNC_ACTIVE
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_pin,
  output logic lead_edge
);

  logic s1;
  logic s2;

  // NOTE: sequential state uses non-blocking assignments so s2 always sees the
  // pre-edge value of s1 regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sync_pin;
      s2 <= s1;
    end
  end

  assign lead_edge = (s1 == ACTIVE_LEVEL) && (s2 != ACTIVE_LEVEL);

endmodule

// File: rtl/vga_timing_receiver.sv
// VGA sink: measures line/frame timing, locks to the configured format and
// recovers per-pixel coordinates and colour one register stage behind the pins.
module vga_timing_receiver
  import vga_timing_pkg::*;
#(
  parameter int   H_TOTAL     = vga_timing_pkg::H_TOTAL,
  parameter int   H_BACK      = vga_timing_pkg::H_BACK,
  parameter int   H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
  parameter int   V_TOTAL     = vga_timing_pkg::V_TOTAL,
  parameter int   V_BACK      = vga_timing_pkg::V_BACK,
  parameter int   V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
  parameter logic SYNC_ACTIVE = vga_timing_pkg::SYNC_ACTIVE,
  parameter int   LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_h_sync,
  input  logic        vga_v_sync,
  input  logic [3:0]  vga_R,
  input  logic [3:0]  vga_G,
  input  logic [3:0]  vga_B,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [11:0] pixel_rgb,
  output logic        pixel_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_error,
  output logic [10:0] line_length,
  output logic [9:0]  frame_lines
);

  localparam logic [10:0] H_LEN     = 11'(H_TOTAL);
  localparam logic [10:0] H_TMO     = 11'(2 * H_TOTAL);
  localparam logic [10:0] H_BEG     = 11'(H_BACK);
  localparam logic [10:0] H_END     = 11'(H_BACK + H_ACTIVE - 1);
  localparam logic [9:0]  V_LEN     = 10'(V_TOTAL);
  localparam logic [9:0]  V_BEG     = 10'(V_BACK);
  localparam logic [9:0]  V_END     = 10'(V_BACK + V_ACTIVE - 1);
  localparam logic [3:0]  LOCK_CNT  = 4'(LOCK_FRAMES);
  localparam logic [10:0] H_MAX     = 11'h7ff;
  localparam logic [9:0]  V_MAX     = 10'h3ff;

  logic      hs_edge;
  logic      vs_edge;
  rgb444_t   rgb_s1;

  vga_sync_edge_detect #(.ACTIVE_LEVEL(SYNC_ACTIVE)) u_hs_edge (
    .clk       (clk),
    .reset     (reset),
    .sync_pin  (vga_h_sync),
    .lead_edge (hs_edge)
  );

  vga_sync_edge_detect #(.ACTIVE_LEVEL(SYNC_ACTIVE)) u_vs_edge (
    .clk       (clk),
    .reset     (reset),
    .sync_pin  (vga_v_sync),
    .lead_edge (vs_edge)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rgb_s1 <= '0;
    else        rgb_s1 <= '{r: vga_R, g: vga_G, b: vga_B};
  end

  logic [10:0] h_idx, h_nxt, period;
  logic [9:0]  v_cnt, v_nxt, lines_now;
  logic        have_h, line_bad;
  logic        h_bad, v_bad, timeout;

  // h_nxt/v_nxt are the indices of the sample now sitting in the s1 stage.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned and infers a latch.
  always_comb begin
    h_nxt = (h_idx == H_MAX) ? h_idx : h_idx + 11'd1;
    if (hs_edge) h_nxt = '0;
    v_nxt = v_cnt;
    if (vs_edge)                       v_nxt = '0;
    else if (hs_edge && v_cnt != V_MAX) v_nxt = v_cnt + 10'd1;
  end

  assign period    = h_idx + 11'd1;
  assign lines_now = v_cnt + 10'd1;
  assign h_bad     = hs_edge && have_h && (period != H_LEN);
  assign v_bad     = vs_edge && (lines_now != V_LEN);
  assign timeout   = (h_nxt == H_TMO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_idx       <= '0;
      v_cnt       <= '0;
      have_h      <= 1'b0;
      line_bad    <= 1'b0;
      line_length <= '0;
      frame_lines <= '0;
    end else begin
      h_idx <= h_nxt;
      v_cnt <= v_nxt;
      if (hs_edge && have_h) line_length <= period;
      if (timeout)           have_h <= 1'b0;
      else if (hs_edge)      have_h <= 1'b1;
      if (vs_edge)           frame_lines <= lines_now;
      if (vs_edge)           line_bad <= 1'b0;
      else if (h_bad)        line_bad <= 1'b1;
    end
  end

  rx_state_t  state, state_nxt;
  logic [3:0] good, good_nxt;
  logic       err_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= SEARCH;
      good         <= '0;
      timing_error <= 1'b0;
    end else begin
      state        <= state_nxt;
      good         <= good_nxt;
      timing_error <= err_nxt;
    end
  end

  // A bad period measured on the hsync edge coincident with vsync still counts
  // against the frame being closed.
  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    err_nxt   = 1'b0;
    unique case (state)
      SEARCH: begin
        if (vs_edge) begin
          state_nxt = VERIFY;
          good_nxt  = '0;
        end
      end
      VERIFY: begin
        if (vs_edge) begin
          if (!(line_bad || h_bad) && lines_now == V_LEN) begin
            good_nxt = good + 4'd1;
            if (good_nxt == LOCK_CNT) state_nxt = LOCKED;
          end else begin
            good_nxt = '0;
          end
        end
      end
      LOCKED: begin
        if (h_bad || v_bad || timeout) begin
          state_nxt = SEARCH;
          good_nxt  = '0;
          err_nxt   = 1'b1;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_rgb   <= '0;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel_x     <= 10'(h_nxt - H_BEG);
      pixel_y     <= v_nxt - V_BEG;
      pixel_rgb   <= rgb_s1;
      pixel_valid <= locked && (h_nxt >= H_BEG) && (h_nxt <= H_END)
                            && (v_nxt >= V_BEG) && (v_nxt <= V_END);
      frame_start <= vs_edge;
    end
  end

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Scoreboard bench for vga_timing_receiver: full 800-clock lines, frames shortened
// to 5 lines (1 back-porch line, 3 active) to keep runs short.
module tb_vga_timing_receiver;

  localparam int HT = 800;
  localparam int HB = 144;
  localparam int HA = 640;
  localparam int HSW = 96;
  localparam int VT = 5;
  localparam int VB = 1;
  localparam int VA = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hs = 1'b1, vs = 1'b1;
  logic [3:0]  r = '0, g = '0, b = '0;
  logic [9:0]  pixel_x, pixel_y, frame_lines;
  logic [11:0] pixel_rgb;
  logic        pixel_valid, frame_start, locked, timing_error;
  logic [10:0] line_length;

  vga_timing_receiver #(.V_TOTAL(VT), .V_BACK(VB), .V_ACTIVE(VA)) dut (
    .clk          (clk),
    .reset        (reset),
    .vga_h_sync   (hs),
    .vga_v_sync   (vs),
    .vga_R        (r),
    .vga_G        (g),
    .vga_B        (b),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .pixel_rgb    (pixel_rgb),
    .pixel_valid  (pixel_valid),
    .frame_start  (frame_start),
    .locked       (locked),
    .timing_error (timing_error),
    .line_length  (line_length),
    .frame_lines  (frame_lines)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] rgb;
  } pix_t;

  pix_t sb[$];
  pix_t exp_pix;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pixel scoreboard plus event bookkeeping for frame_start/lock/error.
  int   fs_count = 0, te_count = 0, te_cyc = 0, te_ll = 0, te_locked = 0;
  int   rise_fs = -1, rise_with_fs = 0, last_fl = 0, pix_seen = 0;
  logic locked_d = 1'b0;

  always @(negedge clk) begin
    if (pixel_valid) begin
      pix_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pixel_unexpected x=%0d y=%0d rgb=%h expected none", pixel_x, pixel_y, pixel_rgb);
      end else begin
        exp_pix = sb.pop_front();
        check("pixel_x", pixel_x, exp_pix.x);
        check("pixel_y", pixel_y, exp_pix.y);
        check("pixel_rgb", pixel_rgb, exp_pix.rgb);
      end
    end
    if (frame_start) begin
      fs_count++;
      last_fl = frame_lines;
    end
    if (timing_error) begin
      te_count++;
      te_cyc    = cyc;
      te_ll     = line_length;
      te_locked = locked;
    end
    if (locked && !locked_d) begin
      rise_fs      = fs_count;
      rise_with_fs = frame_start;
    end
    locked_d = locked;
  end

  function automatic logic [11:0] pattern(input int h, input int line);
    if (h == HB && line == VB) return 12'hF00;
    return 12'(h * 5 + line * 1024 + 3);
  endfunction

  task automatic drive(input logic h, input logic v, input logic [11:0] rgb);
    @(posedge clk);
    #1;
    hs = h;
    vs = v;
    {r, g, b} = rgb;
  endtask

  int hs_lead_cyc = 0;
  int stretch_lead_cyc = 0;

  // Drive samples 0..n_clk-1 of one line; lk says whether the bench expects
  // the receiver locked, in which case active samples are scoreboarded.
  task automatic drive_line(input int line, input int n_clk, input bit lk);
    logic [11:0] px;
    for (int h = 0; h < n_clk; h++) begin
      px = pattern(h, line);
      if (lk && h >= HB && h < HB + HA && line >= VB && line < VB + VA)
        sb.push_back(pix_t'{x: 10'(h - HB), y: 10'(line - VB), rgb: px});
      drive((h < HSW) ? 1'b0 : 1'b1, (line == 0) ? 1'b0 : 1'b1, px);
      if (h == 0) hs_lead_cyc = cyc;
    end
  endtask

  task automatic drive_frame(input int first, input int last_excl, input int stretch, input bit lk);
    for (int line = first; line < last_excl; line++) begin
      drive_line(line, (line == stretch) ? HT + 1 : HT,
                 lk && (stretch < 0 || line <= stretch));
      if (stretch >= 0 && line == stretch + 1) stretch_lead_cyc = hs_lead_cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 12'h000);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pixel_x"}, pixel_x, 0);
    check({tag, "_pixel_y"}, pixel_y, 0);
    check({tag, "_pixel_rgb"}, pixel_rgb, 0);
    check({tag, "_pixel_valid"}, pixel_valid, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_timing_error"}, timing_error, 0);
    check({tag, "_line_length"}, line_length, 0);
    check({tag, "_frame_lines"}, frame_lines, 0);
  endtask

  initial begin
    int fs0, te0, pix0, lead;

    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    @(posedge clk);
    #1 reset = 1'b1;
    idle(4);

    // Standard timing: lock at frame_start of frame 3; frame 3 pixels scoreboarded.
    fs0 = fs_count;
    drive_frame(0, VT, -1, 1'b0);
    drive_frame(0, VT, -1, 1'b0);
    check("locked_before_frame3", locked, 0);
    pix0 = pix_seen;
    drive_frame(0, VT, -1, 1'b1);
    check("lock_rise_frame", rise_fs - fs0, 3);
    check("lock_rise_with_fs", rise_with_fs, 1);
    check("line_length_std", line_length, HT);
    check("frame_lines_std", frame_lines, VT);
    check("no_timing_error", te_count, 0);
    check("pixels_frame3", pix_seen - pix0, HA * VA);
    check("sb_empty_frame3", sb.size(), 0);

    // One 801-clock line while locked, then relock after two good frames.
    te0 = te_count;
    fs0 = fs_count;
    drive_frame(0, VT, 2, 1'b1);
    check("stretch_te_pulses", te_count - te0, 1);
    check("stretch_te_delay", te_cyc - stretch_lead_cyc, 2);
    check("stretch_line_length", te_ll, HT + 1);
    check("stretch_locked_at_te", te_locked, 0);
    check("stretch_locked_after", locked, 0);
    drive_frame(0, VT, -1, 1'b0);
    drive_frame(0, VT, -1, 1'b0);
    drive_frame(0, VT, -1, 1'b1);
    check("relock_frame", rise_fs - fs0, 4);
    check("relock_with_fs", rise_with_fs, 1);
    check("relock_line_length", line_length, HT);
    check("stretch_te_total", te_count - te0, 1);
    check("sb_empty_relock", sb.size(), 0);

    // hsync stops while locked: error at h_idx 1600, counter saturates at 2047.
    te0 = te_count;
    drive_line(0, HT, 1'b1);
    drive_line(1, HT, 1'b1);
    lead = hs_lead_cyc;
    idle(2100);
    check("timeout_te_pulses", te_count - te0, 1);
    check("timeout_te_delay", te_cyc - lead, 2 + 2 * HT);
    check("timeout_locked", locked, 0);
    check("h_idx_saturated", dut.h_idx, 2047);
    check("sb_empty_timeout", sb.size(), 0);

    // Short frame during VERIFY resets the good count: lock one frame later.
    fs0 = fs_count;
    drive_frame(0, VT - 1, -1, 1'b0);
    drive_line(0, HT, 1'b0);
    check("short_frame_lines", last_fl, VT - 1);
    check("short_locked", locked, 0);
    drive_frame(1, VT, -1, 1'b0);
    drive_frame(0, VT, -1, 1'b0);
    check("short_not_yet_locked", locked, 0);
    drive_line(0, HT, 1'b1);
    check("short_lock_frame", rise_fs - fs0, 4);
    check("short_lock_with_fs", rise_with_fs, 1);

    // Asynchronous reset in the middle of an active line.
    drive_line(1, 400, 1'b1);
    #2;
    check("pre_reset_valid", pixel_valid, 1);
    check("pre_reset_locked", locked, 1);
    reset = 1'b0;
    hs = 1'b1;
    vs = 1'b1;
    sb.delete();
    #1;
    check_all_zero("async");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    idle(4);
    fs0 = fs_count;
    drive_frame(0, VT, -1, 1'b0);
    drive_frame(0, VT, -1, 1'b0);
    drive_frame(0, VT, -1, 1'b1);
    check("reset_relock_frame", rise_fs - fs0, 3);
    check("reset_relock_with_fs", rise_with_fs, 1);
    check("reset_relock_ll", line_length, HT);
    check("sb_empty_end", sb.size(), 0);
    check("te_total", te_count, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
